// File: rtl/mean_pkg.sv
`default_nettype none
// mean_pkg -- shared types and constants for the mean_calc datapath and its tile scheduler. rev 1.0
package mean_pkg;

  localparam int LINE_NUM = 12;

  typedef enum logic [1:0] {
    RANK_1_1  = 2'd0,
    RANK_1_4  = 2'd1,
    RANK_1_9  = 2'd2,
    RANK_1_16 = 2'd3
  } rank_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BAND = 3'd1,
    PREFETCH  = 3'd2,
    RUN       = 3'd3,
    PAUSE     = 3'd4,
    BAND_END  = 3'd5
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
// delay -- fixed-latency register pipeline with asynchronous reset to zero. rev 1.0
module delay #(
  parameter int DATA_WIDTH = 1,
  parameter int DELAY_TIME = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (DELAY_TIME == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] stage [DELAY_TIME];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY_TIME; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DELAY_TIME; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DELAY_TIME-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mean_tile_sched.sv
`default_nettype none
// mean_tile_sched -- sweeps each band column by column, one rank per tile, pausing only between tiles. rev 1.0
module mean_tile_sched
  import mean_pkg::*;
#(
  parameter int IMG_W    = 1920,
  parameter int IMG_H    = 1080,
  parameter int LINE_NUM = mean_pkg::LINE_NUM,
  parameter int M_DEPTH  = 11,
  parameter int MAP_AW   = 14,
  parameter int LB_LAT   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_start,
  input  logic               i_band_ready,
  input  logic               i_stall_req,
  output logic               o_map_rd,
  output logic [MAP_AW-1:0]  o_map_addr,
  input  logic [1:0]         i_map_rank,
  output logic               o_lb_rd_en,
  output logic [M_DEPTH-1:0] o_lb_rd_addr,
  output logic               o_data_valid,
  output logic [M_DEPTH-1:0] o_h_count,
  output logic [M_DEPTH-1:0] o_v_count,
  output logic [1:0]         o_rank,
  output logic               o_band_release,
  output logic               o_frame_done,
  output logic               o_busy
);

  localparam int TILES = IMG_W / LINE_NUM;
  localparam int BANDS = IMG_H / LINE_NUM;
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int BW    = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int SW    = $clog2(LINE_NUM);
  localparam int LW    = (LB_LAT > 1) ? $clog2(LB_LAT) : 1;
  localparam int DW    = 1 + 2*M_DEPTH + 2;

  localparam logic [M_DEPTH-1:0] LAST_COL  = M_DEPTH'(IMG_W - 1);
  localparam logic [SW-1:0]      LAST_SUB  = SW'(LINE_NUM - 1);
  localparam logic [TW-1:0]      LAST_TILE = TW'(TILES - 1);
  localparam logic [BW-1:0]      LAST_BAND = BW'(BANDS - 1);
  localparam logic [LW-1:0]      LAST_LAT  = LW'(LB_LAT - 1);

  sched_state_t       state;
  logic [M_DEPTH-1:0] col;
  logic [SW-1:0]      sub;
  logic [TW-1:0]      tile;
  logic [BW-1:0]      band;
  logic [LW-1:0]      lat_cnt;
  rank_t              cur_rank;
  rank_t              nxt_rank;
  rank_t              rank_now;
  logic               first_q;
  logic               nxt_q;
  logic               release_q;
  logic               done_q;
  logic               busy_q;
  logic [MAP_AW-1:0]  tile_sel;
  logic [M_DEPTH-1:0] v_count;
  logic [DW-1:0]      meta_in;
  logic [DW-1:0]      meta_out;

  // Tile 0 is fetched from PREFETCH; later tiles are fetched one tile ahead at sub 0.
  assign o_map_rd   = (state == PREFETCH) ||
                      ((state == RUN) && (sub == '0) && (tile != LAST_TILE));
  assign tile_sel   = (state == RUN) ? MAP_AW'(tile) + MAP_AW'(1) : MAP_AW'(tile);
  assign o_map_addr = o_map_rd ? MAP_AW'(band) * MAP_AW'(TILES) + tile_sel : '0;

  assign o_lb_rd_en     = (state == RUN);
  assign o_lb_rd_addr   = col;
  assign o_band_release = release_q;
  assign o_frame_done   = done_q;
  assign o_busy         = busy_q;

  // The tile-0 rank lands in the same cycle as column 0, so bypass it straight through.
  assign rank_now = first_q ? rank_t'(i_map_rank) : cur_rank;
  assign v_count  = M_DEPTH'(band) * M_DEPTH'(LINE_NUM);
  assign meta_in  = {o_lb_rd_en, col, v_count, rank_now};

  delay #(
    .DATA_WIDTH (DW),
    .DELAY_TIME (LB_LAT)
  ) u_align (
    .clk  (i_clk),
    .rst  (i_rst),
    .din  (meta_in),
    .dout (meta_out)
  );

  assign {o_data_valid, o_h_count, o_v_count, o_rank} = meta_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      col       <= '0;
      sub       <= '0;
      tile      <= '0;
      band      <= '0;
      lat_cnt   <= '0;
      cur_rank  <= RANK_1_1;
      nxt_rank  <= RANK_1_1;
      first_q   <= 1'b0;
      nxt_q     <= 1'b0;
      release_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      first_q   <= (state == PREFETCH);
      nxt_q     <= o_map_rd && (state == RUN);
      release_q <= 1'b0;
      done_q    <= 1'b0;
      if (first_q) cur_rank <= rank_t'(i_map_rank);
      if (nxt_q)   nxt_rank <= rank_t'(i_map_rank);

      case (state)
        IDLE: begin
          busy_q <= i_frame_start;
          if (i_frame_start) begin
            col   <= '0;
            sub   <= '0;
            tile  <= '0;
            band  <= '0;
            state <= WAIT_BAND;
          end
        end
        WAIT_BAND: if (i_band_ready) state <= PREFETCH;
        PREFETCH:  state <= RUN;
        RUN: begin
          if (sub == LAST_SUB) cur_rank <= nxt_rank;
          if (col == LAST_COL) begin
            col     <= '0;
            sub     <= '0;
            tile    <= '0;
            lat_cnt <= '0;
            state   <= BAND_END;
          end else begin
            col <= col + M_DEPTH'(1);
            if (sub == LAST_SUB) begin
              sub  <= '0;
              tile <= tile + TW'(1);
              if (i_stall_req) state <= PAUSE;
            end else begin
              sub <= sub + SW'(1);
            end
          end
        end
        PAUSE: if (!i_stall_req) state <= RUN;
        BAND_END: begin
          if (lat_cnt == LAST_LAT) begin
            release_q <= 1'b1;
            if (band == LAST_BAND) begin
              band   <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              band  <= band + BW'(1);
              state <= WAIT_BAND;
            end
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mean_tile_sched.sv
`default_nettype none
// tb_mean_tile_sched -- directed frames against a queue model of the expected beat stream. rev 1.0
module tb_mean_tile_sched;

  localparam int W   = 24;
  localparam int H   = 24;
  localparam int LN  = 12;
  localparam int MD  = 11;
  localparam int AW  = 14;
  localparam int LAT = 1;
  localparam int NB  = (W / LN) * (H / LN) * LN * 0 + W * (H / LN);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic band_ready = 1'b0;
  logic stall_req = 1'b0;
  logic [1:0] map_rank = 2'd0;

  logic          map_rd;
  logic [AW-1:0] map_addr;
  logic          lb_rd_en;
  logic [MD-1:0] lb_rd_addr;
  logic          data_valid;
  logic [MD-1:0] h_count;
  logic [MD-1:0] v_count;
  logic [1:0]    rank;
  logic          band_release;
  logic          frame_done;
  logic          busy;

  mean_tile_sched #(
    .IMG_W(W), .IMG_H(H), .LINE_NUM(LN), .M_DEPTH(MD), .MAP_AW(AW), .LB_LAT(LAT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_frame_start  (frame_start),
    .i_band_ready   (band_ready),
    .i_stall_req    (stall_req),
    .o_map_rd       (map_rd),
    .o_map_addr     (map_addr),
    .i_map_rank     (map_rank),
    .o_lb_rd_en     (lb_rd_en),
    .o_lb_rd_addr   (lb_rd_addr),
    .o_data_valid   (data_valid),
    .o_h_count      (h_count),
    .o_v_count      (v_count),
    .o_rank         (rank),
    .o_band_release (band_release),
    .o_frame_done   (frame_done),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Rank-map RAM: data valid one cycle after the read strobe.
  logic [1:0] map_mem [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  always @(posedge clk) if (map_rd) map_rank <= map_mem[map_addr[1:0]];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int h;
    int v;
    int r;
  } beat_t;

  beat_t exp_q[$];
  int    addr_q[$];
  int    vcyc [NB];
  int    beat = 0;

  // One frame as the scheduler must present it: every band, every column, rank per tile.
  task automatic load_frame();
    exp_q.delete();
    addr_q.delete();
    for (int b = 0; b < H / LN; b++) begin
      for (int t = 0; t < W / LN; t++) addr_q.push_back(b * (W / LN) + t);
      for (int h = 0; h < W; h++)
        exp_q.push_back('{h, b * LN, int'(map_mem[b * (W / LN) + h / LN])});
    end
    beat = 0;
  endtask

  beat_t bt;
  int    last_h = -1;
  int    last_vc = -1;
  int    last_rd_cyc = 0;
  logic  prev_rd = 1'b0;
  int    prev_addr = 0;
  int    ea;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
      last_vc = -1;
    end else begin
      check("valid_align", data_valid, prev_rd);
      if (data_valid) begin
        check("h_follows_rd_addr", h_count, prev_addr);
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          bt = exp_q.pop_front();
          check("h_count", h_count, bt.h);
          check("v_count", v_count, bt.v);
          check("rank", rank, bt.r);
        end
        if (last_vc >= 0 && cyc - last_vc > 1 && h_count != 0)
          check("gap_at_tile_end", last_h % LN, LN - 1);
        if (beat < NB) vcyc[beat] = cyc;
        beat++;
        last_h  = int'(h_count);
        last_vc = cyc;
      end
      if (map_rd) begin
        check("map_read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) begin
          ea = addr_q.pop_front();
          check("map_addr", map_addr, ea);
        end
      end
      if (band_release) check("release_latency", cyc - last_rd_cyc, LAT + 1);
      if (frame_done)   check("done_with_release", band_release, 1);
      if (lb_rd_en) last_rd_cyc = cyc;
      prev_rd   = lb_rd_en;
      prev_addr = int'(lb_rd_addr);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int t0;
  int rel_cyc;
  int stage;
  int hold;
  int zeros;
  logic pulsed;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", data_valid, 0);
    check("rst_lb_rd_en", lb_rd_en, 0);
    check("rst_map_rd", map_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_release", band_release, 0);
    check("rst_done", frame_done, 0);
    check("rst_rank", rank, 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: nominal, with a 10-cycle band_ready hold after the first release.
    load_frame();
    check("model_rank_tile1", exp_q[12].r, 2);
    check("model_v_band1", exp_q[24].v, 12);
    band_ready  = 1'b1;
    frame_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 200 && !band_release; i++) @(negedge clk);
    check("release1_seen", band_release, 1);
    rel_cyc = cyc;
    band_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("hold_no_read", lb_rd_en, 0);
      check("hold_no_valid", data_valid, 0);
      check("hold_busy", busy, 1);
      check("hold_no_map", map_rd, 0);
    end
    band_ready = 1'b1;
    for (int i = 0; i < 200 && !frame_done; i++) @(negedge clk);
    check("done1_seen", frame_done, 1);
    check("beats_f1", beat, NB);
    check("latency_f1", vcyc[0] - t0, 3 + LAT);
    check("band0_contig_f1", vcyc[W-1] - vcyc[0], W - 1);
    check("band1_restart_f1", vcyc[W] - rel_cyc, 13);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("model_drained_f1", exp_q.size(), 0);

    // Frame 2: ignored mid-tile stall in band 0, honoured tile-boundary stall in band 1.
    load_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    stage = 0; hold = 0; zeros = 0;
    for (int i = 0; i < 400 && !frame_done; i++) begin
      @(negedge clk);
      if (lb_rd_en && lb_rd_addr == 0) zeros++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) stall_req = 1'b0;
      end else if (stage == 0 && lb_rd_en && lb_rd_addr == 5) begin
        stall_req = 1'b1; hold = 4; stage = 1;
      end else if (stage == 1 && zeros == 2 && lb_rd_en && lb_rd_addr == 11) begin
        stall_req = 1'b1; hold = 5; stage = 2;
      end
    end
    check("done2_seen", frame_done, 1);
    check("stall_stimulus_applied", stage, 2);
    check("beats_f2", beat, NB);
    check("band0_contig_f2", vcyc[W-1] - vcyc[0], W - 1);
    check("stall_gap_h11_h12", vcyc[W+12] - vcyc[W+11], 6);
    check("band1_tail_contig", vcyc[NB-1] - vcyc[W+12], 11);
    @(negedge clk);
    check("model_drained_f2", exp_q.size(), 0);

    // Frame 3: reset at h=7 aborts the frame.
    load_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 100 && !(data_valid && h_count == 7); i++) @(negedge clk);
    check("reached_h7", data_valid && h_count == 7, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", data_valid, 0);
    check("arst_h", h_count, 0);
    check("arst_v", v_count, 0);
    check("arst_rank", rank, 0);
    check("arst_lb_rd_en", lb_rd_en, 0);
    check("arst_lb_rd_addr", lb_rd_addr, 0);
    check("arst_map_rd", map_rd, 0);
    check("arst_map_addr", map_addr, 0);
    check("arst_release", band_release, 0);
    check("arst_done", frame_done, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Frame 4: restart after reset, with a frame_start pulse mid-band that must be ignored.
    load_frame();
    frame_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_start = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 300 && !frame_done; i++) begin
      @(negedge clk);
      if (!pulsed && lb_rd_en && lb_rd_addr == 15) begin
        frame_start = 1'b1;
        pulsed = 1'b1;
      end else begin
        frame_start = 1'b0;
      end
    end
    frame_start = 1'b0;
    check("done4_seen", frame_done, 1);
    check("beats_f4", beat, NB);
    check("latency_f4", vcyc[0] - t0, 3 + LAT);
    check("band0_contig_f4", vcyc[W-1] - vcyc[0], W - 1);
    @(negedge clk);
    check("model_drained_f4", exp_q.size(), 0);
    check("map_reads_drained_f4", addr_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
